// File: rtl/fetch_inst_buffer.sv
// Fetch-to-decode decoupling queue: multi-slot enqueue, in-order multi-slot presentation, squash flush.
// Optional FETCHBUF_PERF_EN adds stall-cycle and enqueued-entry counters.
module fetch_inst_buffer #(
  parameter int IN_WIDTH  = 4,
  parameter int OUT_WIDTH = 4,
  parameter int DEPTH     = 16,
  parameter int ENTRY_W   = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_squash_vld,
  input  logic [IN_WIDTH-1:0]           i_inst_vld,
  input  logic [IN_WIDTH*ENTRY_W-1:0]   i_inst,
  output logic                          o_stall,
  output logic [OUT_WIDTH-1:0]          o_inst_vld,
  output logic [OUT_WIDTH*ENTRY_W-1:0]  o_inst,
  input  logic                          i_decode_rdy
`ifdef FETCHBUF_PERF_EN
  ,
  output logic [31:0]                   o_perf_stall_cycles,
  output logic [31:0]                   o_perf_enq_insts
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] ram_q [DEPTH];
  logic [ENTRY_W-1:0] ram_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   n_enq;
  logic [CNT_W-1:0]   n_pres;
  logic [CNT_W-1:0]   n_deq;
  logic               enq_fire;
  logic               deq_fire;

  // Stall looks only at registered occupancy, so it never depends on decode readiness.
  assign o_stall  = (CNT_W'(DEPTH) - count_q) < CNT_W'(IN_WIDTH);
  assign n_pres   = (count_q > CNT_W'(OUT_WIDTH)) ? CNT_W'(OUT_WIDTH) : count_q;
  assign enq_fire = (|i_inst_vld) && !o_stall && !i_squash_vld;
  assign deq_fire = i_decode_rdy && (|o_inst_vld);
  assign n_deq    = deq_fire ? n_pres : '0;

  always_comb begin
    n_enq = '0;
    for (int k = 0; k < IN_WIDTH; k++) begin
      n_enq = n_enq + CNT_W'(i_inst_vld[k]);
    end
  end

  // Unpresented slots read as zero so the outputs are fully quiet after a flush.
  always_comb begin
    o_inst_vld = '0;
    o_inst     = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      if (!i_squash_vld && (CNT_W'(k) < n_pres)) begin
        o_inst_vld[k]                  = 1'b1;
        o_inst[k*ENTRY_W +: ENTRY_W]   = ram_q[head_q + PTR_W'(k)];
      end
    end
  end

  always_comb begin
    ram_d   = ram_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rst || i_squash_vld) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) begin
        for (int k = 0; k < IN_WIDTH; k++) begin
          if (i_inst_vld[k]) begin
            ram_d[tail_q + PTR_W'(k)] = i_inst[k*ENTRY_W +: ENTRY_W];
          end
        end
        tail_d = tail_q + PTR_W'(n_enq);
      end
      if (deq_fire) begin
        head_d = head_q + PTR_W'(n_pres);
      end
      count_d = count_q + (enq_fire ? n_enq : '0) - n_deq;
    end
  end

  always_ff @(posedge clk) begin
    ram_q   <= ram_d;
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
  end

`ifdef FETCHBUF_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_enq_q, perf_enq_d;

  // Squash deliberately leaves the counters running; only reset clears them.
  always_comb begin
    perf_stall_d = perf_stall_q + (o_stall ? 32'd1 : 32'd0);
    perf_enq_d   = perf_enq_q + (enq_fire ? 32'(n_enq) : 32'd0);
    if (rst) begin
      perf_stall_d = '0;
      perf_enq_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    perf_stall_q <= perf_stall_d;
    perf_enq_q   <= perf_enq_d;
  end

  assign o_perf_stall_cycles = perf_stall_q;
  assign o_perf_enq_insts    = perf_enq_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((i_inst_vld & (i_inst_vld + IN_WIDTH'(1))) == '0);
      assert (count_q <= CNT_W'(DEPTH));
      assert (!(enq_fire && o_stall));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Randomized and directed bench for fetch_inst_buffer against a queue-based reference model.
// Define FETCHBUF_PERF_EN to also check the performance counters.
module tb_fetch_inst_buffer;
  localparam int IW = 4;
  localparam int OW = 4;
  localparam int D  = 16;
  localparam int EW = 128;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_squash_vld;
  logic [IW-1:0]  i_inst_vld;
  logic [IW*EW-1:0] i_inst;
  logic           o_stall;
  logic [OW-1:0]  o_inst_vld;
  logic [OW*EW-1:0] o_inst;
  logic           i_decode_rdy;
`ifdef FETCHBUF_PERF_EN
  logic [31:0]    o_perf_stall_cycles;
  logic [31:0]    o_perf_enq_insts;
  int unsigned    m_stall_cyc;
  int unsigned    m_enq_insts;
`endif

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] mq[$];

  always #5 clk = ~clk;

  fetch_inst_buffer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(D), .ENTRY_W(EW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_squash_vld (i_squash_vld),
    .i_inst_vld   (i_inst_vld),
    .i_inst       (i_inst),
    .o_stall      (o_stall),
    .o_inst_vld   (o_inst_vld),
    .o_inst       (o_inst),
    .i_decode_rdy (i_decode_rdy)
`ifdef FETCHBUF_PERF_EN
    ,
    .o_perf_stall_cycles (o_perf_stall_cycles),
    .o_perf_enq_insts    (o_perf_enq_insts)
`endif
  );

  function automatic logic [IW*EW-1:0] rand_data();
    logic [IW*EW-1:0] d;
    for (int i = 0; i < IW*EW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // One clock: drive, check outputs against the model, then advance the model at the edge.
  task automatic cycle(input logic r, input logic sq, input logic [IW-1:0] v,
                       input logic [IW*EW-1:0] d, input logic rd, output logic stall_seen);
    logic             exp_stall;
    logic [OW-1:0]    exp_vld;
    logic [OW*EW-1:0] exp_inst;
    int               n_pres;
    logic             fire;
    @(negedge clk);
    rst = r; i_squash_vld = sq; i_inst_vld = v; i_inst = d; i_decode_rdy = rd;
    #1;
    exp_stall = (D - mq.size()) < IW;
    n_pres    = (mq.size() > OW) ? OW : mq.size();
    exp_vld   = '0;
    exp_inst  = '0;
    if (!sq) begin
      for (int k = 0; k < n_pres; k++) begin
        exp_vld[k] = 1'b1;
        exp_inst[k*EW +: EW] = mq[k];
      end
    end
    checks++;
    if (o_stall !== exp_stall) begin
      errors++;
      $display("FAIL stall: got %0b want %0b at %0t", o_stall, exp_stall, $time);
    end
    checks++;
    if (o_inst_vld !== exp_vld) begin
      errors++;
      $display("FAIL inst_vld: got %b want %b at %0t", o_inst_vld, exp_vld, $time);
    end
    checks++;
    if (o_inst !== exp_inst) begin
      errors++;
      $display("FAIL inst_data: got %h want %h at %0t", o_inst, exp_inst, $time);
    end
`ifdef FETCHBUF_PERF_EN
    checks++;
    if (o_perf_stall_cycles !== m_stall_cyc) begin
      errors++;
      $display("FAIL perf_stall: got %0d want %0d at %0t", o_perf_stall_cycles, m_stall_cyc, $time);
    end
    checks++;
    if (o_perf_enq_insts !== m_enq_insts) begin
      errors++;
      $display("FAIL perf_enq: got %0d want %0d at %0t", o_perf_enq_insts, m_enq_insts, $time);
    end
`endif
    stall_seen = o_stall;
    fire = (v != '0) && !exp_stall && !sq && !r;
    @(posedge clk);
    if (r || sq) begin
      mq.delete();
    end else begin
      if (rd) repeat (n_pres) void'(mq.pop_front());
      if (fire) for (int k = 0; k < IW; k++) if (v[k]) mq.push_back(d[k*EW +: EW]);
    end
`ifdef FETCHBUF_PERF_EN
    if (r) begin
      m_stall_cyc = 0;
      m_enq_insts = 0;
    end else begin
      if (exp_stall) m_stall_cyc++;
      if (fire) m_enq_insts += $countones(v);
    end
`endif
  endtask

  task automatic do_reset();
    logic s;
    cycle(1'b1, 1'b0, '0, '0, 1'b0, s);
  endtask

  task automatic test_reset();
    logic s;
    cycle(1'b0, 1'b0, 4'b1111, rand_data(), 1'b0, s);
    cycle(1'b0, 1'b0, 4'b0011, rand_data(), 1'b0, s);
    cycle(1'b1, 1'b0, 4'b0001, rand_data(), 1'b1, s);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, s);
    checks++;
    if (o_inst_vld !== '0 || o_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%b stall=%0b want vld=0000 stall=0", o_inst_vld, o_stall);
    end
  endtask

  task automatic test_basic();
    logic s;
    do_reset();
    cycle(1'b0, 1'b0, 4'b0111, rand_data(), 1'b0, s);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, s);
    checks++;
    if (o_inst_vld !== 4'b0111) begin
      errors++;
      $display("FAIL basic_vld: got %b want 0111", o_inst_vld);
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1, s);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, s);
  endtask

  task automatic test_fill();
    logic s;
    logic [IW*EW-1:0] hold;
    do_reset();
    repeat (4) cycle(1'b0, 1'b0, 4'b1111, rand_data(), 1'b0, s);
    hold = rand_data();
    cycle(1'b0, 1'b0, 4'b1111, hold, 1'b0, s);
    checks++;
    if (s !== 1'b1) begin
      errors++;
      $display("FAIL fill_stall: got %0b want 1", s);
    end
`ifdef FETCHBUF_PERF_EN
    checks++;
    if (o_perf_enq_insts !== 32'd16) begin
      errors++;
      $display("FAIL fill_perf_enq: got %0d want 16", o_perf_enq_insts);
    end
`endif
    cycle(1'b0, 1'b0, 4'b1111, hold, 1'b1, s);
    cycle(1'b0, 1'b0, 4'b1111, hold, 1'b0, s);
    checks++;
    if (s !== 1'b0) begin
      errors++;
      $display("FAIL release_stall: got %0b want 0", s);
    end
    repeat (5) cycle(1'b0, 1'b0, '0, '0, 1'b1, s);
  endtask

  task automatic test_wrap();
    logic s;
    do_reset();
    repeat (3) cycle(1'b0, 1'b0, 4'b1111, rand_data(), 1'b0, s);
    cycle(1'b0, 1'b0, 4'b0011, rand_data(), 1'b0, s);
    repeat (4) cycle(1'b0, 1'b0, '0, '0, 1'b1, s);
    cycle(1'b0, 1'b0, 4'b1111, rand_data(), 1'b0, s);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, s);
    checks++;
    if (o_inst_vld !== 4'b1111) begin
      errors++;
      $display("FAIL wrap_vld: got %b want 1111", o_inst_vld);
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1, s);
  endtask

  task automatic test_steady();
    logic s;
    int   stalls;
    stalls = 0;
    do_reset();
    repeat (100) begin
      cycle(1'b0, 1'b0, 4'b1111, rand_data(), 1'b1, s);
      if (s) stalls++;
    end
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL steady_stalls: got %0d want 0", stalls);
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1, s);
  endtask

  task automatic test_squash();
    logic s;
    do_reset();
    cycle(1'b0, 1'b0, 4'b1111, rand_data(), 1'b0, s);
    cycle(1'b0, 1'b0, 4'b1111, rand_data(), 1'b0, s);
    cycle(1'b0, 1'b0, 4'b0001, rand_data(), 1'b0, s);
    cycle(1'b0, 1'b1, 4'b0011, rand_data(), 1'b1, s);
    cycle(1'b0, 1'b0, 4'b0011, rand_data(), 1'b0, s);
    checks++;
    if (o_inst_vld !== 4'b0000) begin
      errors++;
      $display("FAIL squash_vld: got %b want 0000", o_inst_vld);
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1, s);
    checks++;
    if (o_inst_vld !== 4'b0011) begin
      errors++;
      $display("FAIL post_squash_vld: got %b want 0011", o_inst_vld);
    end
  endtask

  task automatic test_random();
    logic            s, r, sq, rd, held;
    logic [IW-1:0]   pv;
    logic [IW*EW-1:0] pd;
    int              n;
    held = 1'b0;
    pv = '0;
    pd = '0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 149) == 0);
      sq = ($urandom_range(0, 39) == 0);
      if (!held) begin
        n  = $urandom_range(0, IW);
        pv = IW'((1 << n) - 1);
        pd = rand_data();
      end
      rd = ((i % 200) < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle(r, sq, pv, pd, rd, s);
      held = (pv != '0) && s && !sq && !r;
    end
  endtask

  initial begin
    rst = 1'b1;
    i_squash_vld = 1'b0;
    i_inst_vld = '0;
    i_inst = '0;
    i_decode_rdy = 1'b0;
`ifdef FETCHBUF_PERF_EN
    m_stall_cyc = 0;
    m_enq_insts = 0;
`endif
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_steady();
    test_squash();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
